// File: rtl/half_adder_core.sv
// Registered lane-parallel half adder: per-lane sum/carry captured on valid input,
// with carry summary flags derived from the registered carry vector.

module half_adder_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  logic s_d, c_d, s_q, c_q;

  assign s_d = a_i ^ b_i;
  assign c_d = a_i & b_i;

  // Results hold while en_i is low so a valid gap does not disturb the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (en_i) begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s_o = s_q;
  assign c_o = c_q;
endmodule

module half_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           s,
  output logic [WIDTH-1:0]           c,
  output logic                       carry_any,
  output logic [$clog2(WIDTH+1)-1:0] carry_count
);
  localparam int CW = $clog2(WIDTH+1);

  logic             vld_q;
  logic [WIDTH-1:0] s_q, c_q;
  logic [CW-1:0]    cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= in_valid;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (in_valid),
      .a_i   (a[i]),
      .b_i   (b[i]),
      .s_o   (s_q[i]),
      .c_o   (c_q[i])
    );
  end

  // Summary flags read only the registered carries, so they always match c and
  // hold along with it; CW is sized for WIDTH itself, so the count cannot wrap.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) cnt_d = cnt_d + CW'(c_q[i]);
  end

  assign out_valid   = vld_q;
  assign s           = s_q;
  assign c           = c_q;
  assign carry_any   = |c_q;
  assign carry_count = cnt_d;
endmodule

// File: tb/tb_half_adder_core.sv
// Scoreboard bench for half_adder_core: WIDTH=1 and WIDTH=8 instances side by side.

module tb_half_adder_core;
  typedef struct packed {
    logic [7:0] s;
    logic [7:0] c;
    logic       any;
    logic [3:0] cnt;
  } exp8_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, a1, b1, ov1, s1, c1, any1;
  logic [0:0] cnt1;
  logic       v8, ov8, any8;
  logic [7:0] a8, b8, s8, c8;
  logic [3:0] cnt8;

  half_adder_core #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .out_valid(ov1), .s(s1), .c(c1), .carry_any(any1), .carry_count(cnt1)
  );

  half_adder_core #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .out_valid(ov8), .s(s8), .c(c8), .carry_any(any8), .carry_count(cnt8)
  );

  int    vecs = 0;
  int    errs = 0;
  exp8_t q8[$];
  logic [1:0] q1[$];
  exp8_t last8;

  function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y);
    exp8_t e;
    e.s   = x ^ y;
    e.c   = x & y;
    e.any = |e.c;
    e.cnt = 4'($countones(e.c));
    return e;
  endfunction

  // Drive at the falling edge, then stand 1 time unit past the capturing edge.
  task automatic drive8(input logic v, input logic [7:0] x, input logic [7:0] y, input exp8_t e);
    @(negedge clk);
    v8 = v; a8 = x; b8 = y;
    if (v) q8.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drive1(input logic v, input logic x, input logic y, input logic [1:0] sc);
    @(negedge clk);
    v1 = v; a1 = x; b1 = y;
    if (v) q1.push_back(sc);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp8_t e;
    rst_n = 1'b1; v1 = 0; a1 = 0; b1 = 0; v8 = 0; a8 = 0; b8 = 0;
    #1 rst_n = 1'b0;
    #2;
    vecs++;
    if ({ov8, s8, c8, any8, cnt8, ov1, s1, c1, any1, cnt1} !== '0) begin
      errs++;
      $display("FAIL reset_init: got ov8=%b s8=%h c8=%h any8=%b cnt8=%0d ov1=%b s1=%b c1=%b, want all 0",
               ov8, s8, c8, any8, cnt8, ov1, s1, c1);
    end
    @(negedge clk) rst_n = 1'b1;
    drive8(1'b1, 8'hFF, 8'hFF, model8(8'hFF, 8'hFF));
    vecs++;
    e = q8.pop_front();
    if (ov8 !== 1'b1 || c8 !== e.c) begin
      errs++;
      $display("FAIL reset_prime: got ov=%b c=%h, want ov=1 c=%h", ov8, c8, e.c);
    end
    // Reset between edges must clear outputs without a clock.
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({ov8, s8, c8, any8, cnt8} !== '0) begin
      errs++;
      $display("FAIL reset_async: got ov=%b s=%h c=%h any=%b cnt=%0d, want all 0", ov8, s8, c8, any8, cnt8);
    end
    q8.delete();
    last8 = '0;
    v8 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_w1_exhaustive();
    logic [1:0] ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] sc [4] = '{2'b00, 2'b10, 2'b01, 2'b10};
    logic [1:0] e;
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, ab[i][1], ab[i][0], sc[i]);
      vecs++;
      if (q1.size() == 0) begin
        errs++;
        $display("FAIL w1_%0d: scoreboard empty", i);
      end else begin
        e = q1.pop_front();
        if (ov1 !== 1'b1 || {s1, c1} !== e || any1 !== e[0] || cnt1 !== e[0]) begin
          errs++;
          $display("FAIL w1_%0d: got ov=%b s,c=%b%b any=%b cnt=%0d, want ov=1 s,c=%b any=%b cnt=%0d",
                   i, ov1, s1, c1, any1, cnt1, e, e[0], e[0]);
        end
      end
    end
    @(negedge clk) v1 = 1'b0;
  endtask

  task automatic test_w8_patterns();
    logic [7:0] ta [3] = '{8'hF0, 8'hFF, 8'h00};
    logic [7:0] tb [3] = '{8'h3C, 8'hFF, 8'hA5};
    exp8_t      te [3];
    exp8_t      e;
    te[0] = '{s: 8'hCC, c: 8'h30, any: 1'b1, cnt: 4'd2};
    te[1] = '{s: 8'h00, c: 8'hFF, any: 1'b1, cnt: 4'd8};
    te[2] = '{s: 8'hA5, c: 8'h00, any: 1'b0, cnt: 4'd0};
    for (int i = 0; i < 3; i++) begin
      drive8(1'b1, ta[i], tb[i], te[i]);
      vecs++;
      if (q8.size() == 0) begin
        errs++;
        $display("FAIL w8_pat%0d: scoreboard empty", i);
      end else begin
        e = q8.pop_front();
        last8 = e;
        if (ov8 !== 1'b1 || s8 !== e.s || c8 !== e.c || any8 !== e.any || cnt8 !== e.cnt) begin
          errs++;
          $display("FAIL w8_pat%0d: got ov=%b s=%h c=%h any=%b cnt=%0d, want ov=1 s=%h c=%h any=%b cnt=%0d",
                   i, ov8, s8, c8, any8, cnt8, e.s, e.c, e.any, e.cnt);
        end
      end
    end
  endtask

  task automatic test_valid_gap();
    logic       vp [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'h0F};
    logic [7:0] tb [3] = '{8'h6C, 8'hFF, 8'h33};
    exp8_t      e;
    for (int i = 0; i < 3; i++) begin
      drive8(vp[i], ta[i], tb[i], model8(ta[i], tb[i]));
      vecs++;
      if (vp[i]) begin
        if (q8.size() == 0) begin
          errs++;
          $display("FAIL gap%0d: scoreboard empty", i);
        end else last8 = q8.pop_front();
      end
      e = last8;
      if (ov8 !== vp[i] || s8 !== e.s || c8 !== e.c || any8 !== e.any || cnt8 !== e.cnt) begin
        errs++;
        $display("FAIL gap%0d: got ov=%b s=%h c=%h any=%b cnt=%0d, want ov=%b s=%h c=%h any=%b cnt=%0d",
                 i, ov8, s8, c8, any8, cnt8, vp[i], e.s, e.c, e.any, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] x, y;
    exp8_t      e;
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      drive8(1'b1, x, y, model8(x, y));
      vecs++;
      if (q8.size() == 0) begin
        errs++;
        $display("FAIL b2b%0d: scoreboard empty", i);
      end else begin
        e = q8.pop_front();
        last8 = e;
        if (ov8 !== 1'b1 || s8 !== e.s || c8 !== e.c || any8 !== e.any || cnt8 !== e.cnt) begin
          errs++;
          $display("FAIL b2b%0d: a=%h b=%h got s=%h c=%h any=%b cnt=%0d, want s=%h c=%h any=%b cnt=%0d",
                   i, x, y, s8, c8, any8, cnt8, e.s, e.c, e.any, e.cnt);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp8_t e;
    drive8(1'b1, 8'hC3, 8'hE1, model8(8'hC3, 8'hE1));
    void'(q8.pop_front());
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({ov8, s8, c8, any8, cnt8} !== '0) begin
      errs++;
      $display("FAIL mid_async: got ov=%b s=%h c=%h any=%b cnt=%0d, want all 0", ov8, s8, c8, any8, cnt8);
    end
    // Valid input during reset must not be captured.
    @(negedge clk) begin v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
    @(posedge clk); #1;
    vecs++;
    if ({ov8, s8, c8, any8, cnt8} !== '0) begin
      errs++;
      $display("FAIL mid_held: got ov=%b s=%h c=%h any=%b cnt=%0d, want all 0", ov8, s8, c8, any8, cnt8);
    end
    q8.delete();
    last8 = '0;
    @(negedge clk) begin v8 = 1'b0; rst_n = 1'b1; end
    drive8(1'b0, 8'h77, 8'h77, model8(8'h77, 8'h77));
    vecs++;
    if (ov8 !== 1'b0 || s8 !== 8'h00 || c8 !== 8'h00) begin
      errs++;
      $display("FAIL mid_idle: got ov=%b s=%h c=%h, want ov=0 s=00 c=00", ov8, s8, c8);
    end
    drive8(1'b1, 8'h3E, 8'h2B, model8(8'h3E, 8'h2B));
    vecs++;
    e = q8.pop_front();
    if (ov8 !== 1'b1 || s8 !== e.s || c8 !== e.c || any8 !== e.any || cnt8 !== e.cnt) begin
      errs++;
      $display("FAIL mid_resume: got ov=%b s=%h c=%h any=%b cnt=%0d, want ov=1 s=%h c=%h any=%b cnt=%0d",
               ov8, s8, c8, any8, cnt8, e.s, e.c, e.any, e.cnt);
    end
    @(negedge clk) v8 = 1'b0;
  endtask

  initial begin
    last8 = '0;
    test_reset();
    test_w1_exhaustive();
    test_w8_patterns();
    test_valid_gap();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
